phys_regfile_scoreboard: RTL
============================

Name: phys_regfile_scoreboard

Overview:
- Parametrised successor to the core's physical register file: banked LUTRAM storage with one bank per writeback group, plus a per-register in-use scoreboard and issue-stage bypass registers.
- Adds a configurable physical-register depth and data width.
- Adds an explicit in-use bit table with defined set/clear priority in place of toggle memory.
- Adds a same-cycle writeback-to-decode bypass and a self-sequenced clear sweep that zeroes every register and scoreboard entry after reset or on request.

Parameters:
- NUM_WB_GROUPS, 2, number of writeback groups/banks (>=1)
- READ_PORTS, 2, number of source read ports
- PHYS_REGS, 64, physical register count (power of two, >=32); ADDR_W = clog2(PHYS_REGS)
- DATA_WIDTH, 32, register width
- ZERO_HARDWIRED, 1, when 1, physical register 0 always reads 0, is never marked in use and is never written

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_clear  in  1  restart the clear sweep (same effect as rst on FSM and scoreboard)
- ready  out  1  high when the sweep is complete; decode must stall while low
- decode_rs_addr  in  READ_PORTS x ADDR_W  decode source physical addresses
- decode_rs_wb_group  in  READ_PORTS x clog2(NUM_WB_GROUPS)  producing group per source
- decode_rd_addr  in  ADDR_W  destination physical register being allocated
- decode_uses_rd  in  1  instruction writes rd
- decode_advance  in  1  decode-to-issue transfer this cycle
- fetch_flush  in  1  suppresses allocation
- issue_rs_addr  in  READ_PORTS x ADDR_W  issue-stage source addresses for the in-use query
- issue_rs_inuse  out  READ_PORTS  source still pending
- issue_rs_data  out  READ_PORTS x DATA_WIDTH  operand data
- retire_valid  in  1  single-cycle completion or flush release
- retire_addr  in  ADDR_W  register released by retire_valid
- wb_valid  in  NUM_WB_GROUPS  writeback commit per group
- wb_addr  in  NUM_WB_GROUPS x ADDR_W  writeback address per group
- wb_data  in  NUM_WB_GROUPS x DATA_WIDTH  writeback data per group
- writeback_suppress  in  1  blocks bank writes; scoreboard clears still occur

Behaviour:
- FSM, two states:
  - SWEEP: entered on rst or init_clear, from any state, counter reset to 0. Each cycle writes 0 to address counter in every bank and clears inuse[counter]; counter increments.
  - RUN: entered after counter = PHYS_REGS-1 is written.
  - ready is 1 only in RUN, so ready rises exactly PHYS_REGS cycles after the last cycle rst/init_clear is high. rst or init_clear asserted mid-sweep restarts the sweep at 0.
- Reset values:
  - ready = 0; issue_rs_inuse = 0 (forced to 0 while not RUN).
  - issue_rs_data = 0: the registered file output is cleared and the issue mux selects the file output.
- Inputs ignored while not RUN: decode_advance, wb_valid, retire_valid.
- Scoreboard, one bit per register:
  - set when decode_advance & decode_uses_rd & ~fetch_flush & (rd != 0 | ~ZERO_HARDWIRED);
  - cleared when wb_valid[g] hits the address, for any g, or when retire_valid hits retire_addr;
  - set has priority over clear on the same address in the same cycle;
  - updated values are visible on the next cycle.
- Decode read:
  - banks are read combinationally at decode_rs_addr.
  - On decode_advance, per port: the file register loads 0 if the address is 0 and ZERO_HARDWIRED; otherwise wb_data[g] if wb_valid[g] & wb_addr[g] == rs this cycle (same-cycle bypass, lowest matching g wins); otherwise bank[decode_rs_wb_group] data.
  - On decode_advance, per port, issue_sel latches "bypass group decode_rs_wb_group" if inuse[rs] is set and not cleared this cycle, else "file".
- Bypass registers [group][port]: load wb_data[group] when decode_advance or issue_rs_inuse[port]. They therefore hold the last writeback seen while the operand was pending.
- issue_rs_data[p] = selected bypass register or file register, per issue_sel[p].
- Bank writes: wb_valid[g] & ~writeback_suppress & (wb_addr != 0 | ~ZERO_HARDWIRED). The write is visible to decode reads on the next cycle.

Test Plan:
- rst high 3 cycles, PHYS_REGS=64 -> ready low through 64 cycles after rst falls, high on cycle 64; reading any register then gives 0 data and inuse 0.
- Allocate rd=5, then 4 cycles later wb group 1 addr 5 data 0xDEADBEEF; a consumer decoded in between with rs=5, group 1 -> issue_rs_inuse high until the cycle after the wb, then issue_rs_data = 0xDEADBEEF.
- decode_advance with rs=7 in the same cycle as wb group 0 addr 7 data 0x1234 -> issue_rs_data = 0x1234 next cycle, inuse 0.
- rd=0 with ZERO_HARDWIRED=1, wb to addr 0 data 0xFF -> inuse[0] stays 0 and reads of rs=0 return 0.
- Allocate rd=9 and retire_valid addr 9 in the same cycle -> inuse[9] = 1. A later wb addr 9 with writeback_suppress=1 -> inuse cleared, bank data unchanged.
- init_clear at sweep counter 20, then again in RUN -> sweep restarts at 0, ready low for 64 cycles each time, all previously written data reads 0.

Source files
------------

// File: rtl/phys_regfile_scoreboard.sv
// rtl/phys_regfile_scoreboard.sv - banked physical register file with in-use scoreboard, issue bypass and clear sweep
module phys_regfile_scoreboard #(
    parameter int NUM_WB_GROUPS  = 2,
    parameter int READ_PORTS     = 2,
    parameter int PHYS_REGS      = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ZERO_HARDWIRED = 1,
    localparam int ADDR_W = $clog2(PHYS_REGS),
    localparam int GRP_W  = (NUM_WB_GROUPS > 1) ? $clog2(NUM_WB_GROUPS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      init_clear,
    output logic                                      ready,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]         decode_rs_addr,
    input  logic [READ_PORTS-1:0][GRP_W-1:0]          decode_rs_wb_group,
    input  logic [ADDR_W-1:0]                         decode_rd_addr,
    input  logic                                      decode_uses_rd,
    input  logic                                      decode_advance,
    input  logic                                      fetch_flush,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]         issue_rs_addr,
    output logic [READ_PORTS-1:0]                     issue_rs_inuse,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]     issue_rs_data,
    input  logic                                      retire_valid,
    input  logic [ADDR_W-1:0]                         retire_addr,
    input  logic [NUM_WB_GROUPS-1:0]                  wb_valid,
    input  logic [NUM_WB_GROUPS-1:0][ADDR_W-1:0]      wb_addr,
    input  logic [NUM_WB_GROUPS-1:0][DATA_WIDTH-1:0]  wb_data,
    input  logic                                      writeback_suppress
);

    typedef enum logic {ST_SWEEP, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PHYS_REGS - 1);

    state_t                                  state_q, state_d;
    logic [ADDR_W-1:0]                       cnt_q, cnt_d;
    logic                                    run;
    logic                                    restart;
    logic                                    dec_adv;
    logic                                    ret_v;
    logic [NUM_WB_GROUPS-1:0]                wb_v;

    logic [DATA_WIDTH-1:0]                   bank [NUM_WB_GROUPS][PHYS_REGS];
    logic [PHYS_REGS-1:0]                    inuse;
    logic [PHYS_REGS-1:0]                    set_vec, clr_vec;

    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   file_d, file_q;
    logic [READ_PORTS-1:0]                   sel_byp_d, sel_byp_q;
    logic [READ_PORTS-1:0][GRP_W-1:0]        sel_grp_q;
    logic [NUM_WB_GROUPS-1:0][READ_PORTS-1:0][DATA_WIDTH-1:0] byp_q;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_HARDWIRED != 0) && (a == '0);
    endfunction

    assign run     = (state_q == ST_RUN);
    assign restart = rst | init_clear;
    assign ready   = run;
    assign dec_adv = decode_advance & run;
    assign ret_v   = retire_valid & run;
    assign wb_v    = wb_valid & {NUM_WB_GROUPS{run}};

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (dec_adv && decode_uses_rd && !fetch_flush && !is_zero(decode_rd_addr)) begin
            set_vec[decode_rd_addr] = 1'b1;
        end
        for (int g = 0; g < NUM_WB_GROUPS; g++) begin
            if (wb_v[g]) begin
                clr_vec[wb_addr[g]] = 1'b1;
            end
        end
        if (ret_v) begin
            clr_vec[retire_addr] = 1'b1;
        end
    end

    // Set wins over clear: an allocation racing a stale release must stay pending.
    always_ff @(posedge clk) begin
        if (restart) begin
            inuse <= '0;
        end else if (!run) begin
            inuse[cnt_q] <= 1'b0;
        end else begin
            inuse <= (inuse & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_WB_GROUPS; g++) begin
            if (!run) begin
                bank[g][cnt_q] <= '0;
            end else if (wb_v[g] && !writeback_suppress && !is_zero(wb_addr[g])) begin
                bank[g][wb_addr[g]] <= wb_data[g];
            end
        end
    end

    // Descending scan so the lowest-numbered matching writeback group wins.
    always_comb begin
        file_d    = '0;
        sel_byp_d = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            file_d[p] = bank[decode_rs_wb_group[p]][decode_rs_addr[p]];
            for (int g = NUM_WB_GROUPS - 1; g >= 0; g--) begin
                if (wb_v[g] && (wb_addr[g] == decode_rs_addr[p])) begin
                    file_d[p] = wb_data[g];
                end
            end
            if (is_zero(decode_rs_addr[p])) begin
                file_d[p] = '0;
            end
            sel_byp_d[p] = inuse[decode_rs_addr[p]] & ~clr_vec[decode_rs_addr[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            file_q    <= '0;
            sel_byp_q <= '0;
            sel_grp_q <= '0;
            byp_q     <= '0;
        end else begin
            if (dec_adv) begin
                file_q    <= file_d;
                sel_byp_q <= sel_byp_d;
                sel_grp_q <= decode_rs_wb_group;
            end
            for (int g = 0; g < NUM_WB_GROUPS; g++) begin
                for (int p = 0; p < READ_PORTS; p++) begin
                    if (dec_adv || issue_rs_inuse[p]) begin
                        byp_q[g][p] <= wb_data[g];
                    end
                end
            end
        end
    end

    always_comb begin
        issue_rs_inuse = '0;
        issue_rs_data  = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            issue_rs_inuse[p] = run & inuse[issue_rs_addr[p]];
            issue_rs_data[p]  = sel_byp_q[p] ? byp_q[sel_grp_q[p]][p] : file_q[p];
        end
    end

endmodule
